// File: rtl/stack_arbiter_if.sv
// Requester, response and stack-command signals shared between stack_arbiter
// (slave side) and whatever drives requests and hosts the stack (master side).
interface stack_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_op;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_error;

  logic              req1_valid;
  logic              req1_op;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_error;

  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] stk_data_in;
  logic [DATA_W-1:0] stk_data_out;
  logic              stk_error;

  modport slave (
    input  req0_valid, req0_op, req0_data,
    input  req1_valid, req1_op, req1_data,
    input  stk_data_out, stk_error,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_error,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_error,
    output stk_push, stk_pop, stk_data_in
  );

  modport master (
    output req0_valid, req0_op, req0_data,
    output req1_valid, req1_op, req1_data,
    output stk_data_out, stk_error,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_error,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_error,
    input  stk_push, stk_pop, stk_data_in
  );
endinterface

// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of a fixed-latency stack, one op in flight.
// Define STACK_ARB_FIXED_PRI_EN to make requester 0 win every tie (else round-robin).
//
// state | meaning
// IDLE  | no op in flight; grant a pending requester
// ISSUE | drive stk_push/stk_pop for one cycle (skipped if rejected locally)
// WAIT  | LAT cycles for the stack; capture its result on the last one
// RESP  | one-cycle response pulse to the granted requester
module stack_arbiter #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int LAT    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  stack_arbiter_if.slave         bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                armed_q, armed_d;
  logic                gnt_q, gnt_d;
  logic                op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rej_q, rej_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;
  logic                cap_err_q, cap_err_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                win;
  logic                win_op;
  logic [DATA_W-1:0]   win_data;

`ifdef STACK_ARB_FIXED_PRI_EN
  assign win = !bus.req0_valid;
`else
  logic ptr_q, ptr_d;
  // ptr_q names the requester that wins the next tie
  assign win = (bus.req0_valid && bus.req1_valid) ? ptr_q : !bus.req0_valid;
`endif

  assign win_op   = win ? bus.req1_op   : bus.req0_op;
  assign win_data = win ? bus.req1_data : bus.req0_data;

  assign count = count_q;
  assign busy  = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    armed_d    = 1'b1;
    gnt_d      = gnt_q;
    op_d       = op_q;
    data_d     = data_q;
    rej_d      = rej_q;
    cap_data_d = cap_data_q;
    cap_err_d  = cap_err_q;
    count_d    = count_q;
    wait_d     = wait_q;
`ifndef STACK_ARB_FIXED_PRI_EN
    ptr_d      = ptr_q;
`endif
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.rsp0_valid  = 1'b0;
    bus.rsp1_valid  = 1'b0;
    bus.rsp0_data   = '0;
    bus.rsp1_data   = '0;
    bus.rsp0_error  = 1'b0;
    bus.rsp1_error  = 1'b0;
    bus.stk_push    = 1'b0;
    bus.stk_pop     = 1'b0;
    bus.stk_data_in = '0;

    case (state_q)
      IDLE: begin
        // armed_q holds off grants for the first cycle after reset release
        if (armed_q && (bus.req0_valid || bus.req1_valid)) begin
          bus.req0_ready = !win;
          bus.req1_ready = win;
          gnt_d      = win;
          op_d       = win_op;
          data_d     = win_data;
          rej_d      = win_op ? (count_q == FULL) : (count_q == '0);
          cap_data_d = '0;
          cap_err_d  = 1'b0;
`ifndef STACK_ARB_FIXED_PRI_EN
          ptr_d      = !win;
`endif
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (rej_q) begin
          state_d = RESP;
        end else begin
          bus.stk_push    = op_q;
          bus.stk_pop     = !op_q;
          bus.stk_data_in = data_q;
          count_d = op_q ? count_q + 1'b1 : count_q - 1'b1;
          wait_d  = WAIT_W'(LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          cap_data_d = bus.stk_data_out;
          cap_err_d  = bus.stk_error;
          state_d    = RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      RESP: begin
        bus.rsp0_valid = !gnt_q;
        bus.rsp1_valid = gnt_q;
        bus.rsp0_error = !gnt_q && (rej_q || cap_err_q);
        bus.rsp1_error = gnt_q && (rej_q || cap_err_q);
        if (!op_q && !rej_q && !cap_err_q) begin
          bus.rsp0_data = gnt_q ? '0 : cap_data_q;
          bus.rsp1_data = gnt_q ? cap_data_q : '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      gnt_q      <= 1'b0;
      op_q       <= 1'b0;
      data_q     <= '0;
      rej_q      <= 1'b0;
      cap_data_q <= '0;
      cap_err_q  <= 1'b0;
      count_q    <= '0;
      wait_q     <= '0;
`ifndef STACK_ARB_FIXED_PRI_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      data_q     <= data_d;
      rej_q      <= rej_d;
      cap_data_q <= cap_data_d;
      cap_err_q  <= cap_err_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
`ifndef STACK_ARB_FIXED_PRI_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter: directed ops push expected responses,
// a negedge monitor pops and compares them; a behavioural stack sits behind the DUT.
module tb_stack_arbiter;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int LAT    = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic busy;

  stack_arbiter_if #(.DATA_W(DATA_W)) bus();

  stack_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic       err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  logic inject_err = 1'b0;
  int   last_g;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural stack: result is held from the cycle after the command onward
  logic [7:0] mem [0:31];
  logic [5:0] sp;
  int n_push = 0;
  int n_pop = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= '0;
      bus.stk_data_out <= '0;
      bus.stk_error <= 1'b0;
    end else if (bus.stk_push) begin
      mem[sp[4:0]] <= bus.stk_data_in;
      sp <= sp + 6'd1;
      bus.stk_data_out <= '0;
      bus.stk_error <= inject_err || (sp >= 6'(DEPTH));
      n_push <= n_push + 1;
    end else if (bus.stk_pop) begin
      bus.stk_data_out <= (sp != 0) ? mem[sp[4:0] - 5'd1] : 8'h00;
      sp <= (sp != 0) ? sp - 6'd1 : 6'd0;
      bus.stk_error <= inject_err || (sp == 0);
      n_pop <= n_pop + 1;
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (bus.stk_push || bus.stk_pop)
      check("stk_exclusive", int'(bus.stk_push && bus.stk_pop), 0);
    if (bus.rsp0_valid || bus.rsp1_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=rsp0:%0d rsp1:%0d expected=none", bus.rsp0_valid, bus.rsp1_valid);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_valid_vec", int'({bus.rsp1_valid, bus.rsp0_valid}), (mon_e.id != 0) ? 2 : 1);
        check("rsp_error", int'(mon_e.id != 0 ? bus.rsp1_error : bus.rsp0_error), int'(mon_e.err));
        check("rsp_data", int'(mon_e.id != 0 ? bus.rsp1_data : bus.rsp0_data), int'(mon_e.data));
        check("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic issue(int id, logic op, logic [7:0] d, logic rej, logic [7:0] rdata);
    bit got = 0;
    @(negedge clk);
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_data = d;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if ((id == 0) ? bus.req0_ready : bus.req1_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual=no_ready expected=ready req=%0d", id);
      return;
    end
    last_g = cyc;
    sb.push_back('{id, rej | inject_err, rdata, cyc + (rej ? 2 : LAT + 2)});
    gnt_log.push_back(id);
    @(posedge clk);
  endtask

  task automatic drop(int id);
    #1;
    if (id == 0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #2;
      if (!busy && sb.size() == 0) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy:%0d pending:%0d expected=idle", busy, sb.size());
    end
  endtask

  task automatic do_op(int id, logic op, logic [7:0] d, logic rej, logic [7:0] rdata);
    issue(id, op, d, rej, rdata);
    drop(id);
    wait_idle();
  endtask

  int rel;
  int base;
  int exp_alt [4];

  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_data = '0;

    // push request already pending while reset is held
    bus.req0_valid = 1'b1; bus.req0_op = 1'b1; bus.req0_data = 8'hA5;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready0", int'(bus.req0_ready), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;

    issue(0, 1'b1, 8'hA5, 1'b0, 8'h00);
    check("first_grant_cycle", last_g - rel, 1);
    #1;
    check("issue_push", int'(bus.stk_push), 1);
    check("issue_pop", int'(bus.stk_pop), 0);
    check("issue_data_in", int'(bus.stk_data_in), 8'hA5);
    check("issue_busy", int'(busy), 1);
    drop(0);
    wait_idle();
    check("count_after_a5", int'(count), 1);
    check("npush_after_a5", n_push, 1);

    do_op(0, 1'b0, 8'h00, 1'b0, 8'hA5);
    check("count_after_pop_a5", int'(count), 0);

    do_op(0, 1'b1, 8'h11, 1'b0, 8'h00);
    do_op(0, 1'b1, 8'h22, 1'b0, 8'h00);
    check("count_two", int'(count), 2);
    do_op(0, 1'b0, 8'h00, 1'b0, 8'h22);
    do_op(0, 1'b0, 8'h00, 1'b0, 8'h11);
    check("count_lifo_done", int'(count), 0);
    check("npop_lifo", n_pop, 3);

    // underflow from requester 1: rejected locally, no stack command
    do_op(1, 1'b0, 8'h00, 1'b1, 8'h00);
    check("count_underflow", int'(count), 0);
    check("npop_underflow", n_pop, 3);

    // both requesters hold valid; requester 1 was granted last
`ifdef STACK_ARB_FIXED_PRI_EN
    exp_alt[0] = 0; exp_alt[1] = 0; exp_alt[2] = 1; exp_alt[3] = 1;
`else
    exp_alt[0] = 0; exp_alt[1] = 1; exp_alt[2] = 0; exp_alt[3] = 1;
`endif
    base = gnt_log.size();
    fork
      begin
        issue(0, 1'b1, 8'h30, 1'b0, 8'h00);
        issue(0, 1'b1, 8'h31, 1'b0, 8'h00);
        drop(0);
      end
      begin
        issue(1, 1'b1, 8'h40, 1'b0, 8'h00);
        issue(1, 1'b1, 8'h41, 1'b0, 8'h00);
        drop(1);
      end
    join
    wait_idle();
    for (int i = 0; i < 4; i++)
      check($sformatf("arb_grant_%0d", i), (gnt_log.size() > base + i) ? gnt_log[base + i] : -1, exp_alt[i]);
    check("count_after_arb", int'(count), 4);

    for (int i = 0; i < 12; i++) do_op(0, 1'b1, 8'(i), 1'b0, 8'h00);
    check("count_full", int'(count), 16);
    do_op(0, 1'b1, 8'hEE, 1'b1, 8'h00);
    check("count_overflow", int'(count), 16);
    check("npush_overflow", n_push, 19);

    do_op(1, 1'b0, 8'h00, 1'b0, 8'd11);
    check("count_after_top_pop", int'(count), 15);

    inject_err = 1'b1;
    do_op(0, 1'b0, 8'h00, 1'b0, 8'h00);
    inject_err = 1'b0;
    check("count_after_stk_err", int'(count), 14);

    // reset while waiting on the stack: op abandoned, no response
    issue(0, 1'b1, 8'h77, 1'b0, 8'h00);
    drop(0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("wait_busy_pre_reset", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_stk_cmd", int'({bus.stk_push, bus.stk_pop}), 0);
    check("rst_rsp", int'({bus.rsp0_valid, bus.rsp1_valid}), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_op(0, 1'b1, 8'h5A, 1'b0, 8'h00);
    check("count_post_reset", int'(count), 1);
    do_op(0, 1'b0, 8'h00, 1'b0, 8'h5A);
    check("count_post_reset_pop", int'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
